// File: rtl/vehicle_call_detector.sv
// Loop-detector front end: synchronise, debounce and latch highway/country vehicle calls.
// Optional stuck-loop fault detection is built when STUCK_DETECT_EN is defined.
module vehicle_call_detector #(
    parameter int unsigned TICK_DIV    = 10,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned STUCK_TICKS = 60,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic loop_high_raw,
    input  logic loop_country_raw,
    input  logic greenhigh,
    input  logic greencountry,
    output logic highway_road,
    output logic country_road,
    output logic fault_high,
    output logic fault_country
);

    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NAPP = 2;

    // Bit 0 is the highway approach, bit 1 the country approach.
    logic [NAPP-1:0]  raw;
    logic [NAPP-1:0]  green;
    logic [NAPP-1:0]  sync1_q, sync2_q;
    logic [NAPP-1:0]  occ_q, occ_d;
    logic [NAPP-1:0]  occ_prev_q;
    logic [NAPP-1:0]  occ_rise;
    logic [NAPP-1:0]  call_q, call_d;
    logic [NAPP-1:0]  road_q, road_d;
    logic [CNT_W-1:0] deb_cnt_q [NAPP];
    logic [CNT_W-1:0] deb_cnt_d [NAPP];
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;

    assign raw   = {loop_country_raw, loop_high_raw};
    assign green = {greencountry, greenhigh};

    // Sample-tick prescaler; with TICK_DIV = 1 the count sits at 0 and tick is always high.
    always_comb begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Debounce, edge detect, call latch and output next-state.
    always_comb begin
        occ_d    = occ_q;
        occ_rise = occ_q & ~occ_prev_q;
        call_d   = (call_q | occ_rise) & ~green;
        road_d   = call_q | occ_q;
        for (int i = 0; i < int'(NAPP); i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == occ_q[i]) begin
                    deb_cnt_d[i] = '0;
                end else if (deb_cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    occ_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            occ_q      <= '0;
            occ_prev_q <= '0;
            call_q     <= '0;
            road_q     <= '0;
            presc_q    <= '0;
            for (int i = 0; i < int'(NAPP); i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            occ_q      <= occ_d;
            occ_prev_q <= occ_q;
            call_q     <= call_d;
            road_q     <= road_d;
            presc_q    <= presc_d;
            for (int i = 0; i < int'(NAPP); i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign highway_road = road_q[0];
    assign country_road = road_q[1];

`ifdef STUCK_DETECT_EN
    logic [CNT_W-1:0] stk_cnt_q [NAPP];
    logic [CNT_W-1:0] stk_cnt_d [NAPP];
    logic [NAPP-1:0]  fault_q, fault_d;

    // Occupied-time counter saturates at STUCK_TICKS; the fault flag is sticky until reset.
    always_comb begin
        fault_d = fault_q;
        for (int i = 0; i < int'(NAPP); i++) begin
            stk_cnt_d[i] = stk_cnt_q[i];
            if (!occ_q[i]) begin
                stk_cnt_d[i] = '0;
            end else if (tick && (stk_cnt_q[i] != CNT_W'(STUCK_TICKS))) begin
                stk_cnt_d[i] = stk_cnt_q[i] + CNT_W'(1);
            end
            if (stk_cnt_q[i] == CNT_W'(STUCK_TICKS)) begin
                fault_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= '0;
            for (int i = 0; i < int'(NAPP); i++) begin
                stk_cnt_q[i] <= '0;
            end
        end else begin
            fault_q <= fault_d;
            for (int i = 0; i < int'(NAPP); i++) begin
                stk_cnt_q[i] <= stk_cnt_d[i];
            end
        end
    end

    assign fault_high    = fault_q[0];
    assign fault_country = fault_q[1];
`else
    assign fault_high    = 1'b0;
    assign fault_country = 1'b0;
`endif

endmodule

// File: tb/tb_vehicle_call_detector.sv
// Directed bench for vehicle_call_detector: one TICK_DIV=1 instance and one TICK_DIV=10 instance.
module tb_vehicle_call_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, hr, cr, gh, gc;
    logic hw, cw, fh, fc;
    logic p_reset, p_hr, p_cr;
    logic p_hw, p_cw, p_fh, p_fc;

    vehicle_call_detector #(.TICK_DIV(1), .DEB_CYCLES(4), .STUCK_TICKS(60), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .loop_high_raw(hr), .loop_country_raw(cr),
        .greenhigh(gh), .greencountry(gc),
        .highway_road(hw), .country_road(cw),
        .fault_high(fh), .fault_country(fc)
    );

    vehicle_call_detector #(.TICK_DIV(10), .DEB_CYCLES(4), .STUCK_TICKS(60), .CNT_W(8)) dut_p (
        .clk(clk), .reset(p_reset),
        .loop_high_raw(p_hr), .loop_country_raw(p_cr),
        .greenhigh(1'b0), .greencountry(1'b0),
        .highway_road(p_hw), .country_road(p_cw),
        .fault_high(p_fh), .fault_country(p_fc)
    );

`ifdef STUCK_DETECT_EN
    localparam logic FAULT_EN = 1'b1;
`else
    localparam logic FAULT_EN = 1'b0;
`endif

    typedef struct {
        string tag;
        logic  val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_val(input string tag, input logic val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed=%b required=<none>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.val);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic p_do_reset();
        p_reset = 1'b1;
        cyc(2);
        p_reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hr = 1'b0; cr = 1'b0; gh = 1'b0; gc = 1'b0;
        p_reset = 1'b1; p_hr = 1'b0; p_cr = 1'b0;
        #1;
        expect_val("rst_hw", 1'b0); check(hw);
        expect_val("rst_cw", 1'b0); check(cw);
        expect_val("rst_fh", 1'b0); check(fh);
        expect_val("rst_fc", 1'b0); check(fc);
        cyc(2);
        reset = 1'b0; p_reset = 1'b0;

        // Reset: outputs high first, then async reset clears them; release requalifies in 7 cycles.
        cyc(2);
        hr = 1'b1; cr = 1'b1;
        expect_val("t1_hw_c6", 1'b0); cyc(6); check(hw);
        expect_val("t1_hw_c7", 1'b1); cyc(1); check(hw);
        expect_val("t1_cw_c7", 1'b1); check(cw);
        #1 reset = 1'b1;
        #1;
        expect_val("t1_hw_async", 1'b0); check(hw);
        expect_val("t1_cw_async", 1'b0); check(cw);
        cyc(3);
        expect_val("t1_cw_held", 1'b0); check(cw);
        reset = 1'b0;
        expect_val("t1_cw_rel_c6", 1'b0); cyc(6); check(cw);
        expect_val("t1_cw_rel_c7", 1'b1); cyc(1); check(cw);

        // Glitch reject: 3-cycle pulse is dropped, 4-cycle pulse is accepted and latched.
        hr = 1'b0; cr = 1'b0;
        do_reset();
        cr = 1'b1; cyc(3); cr = 1'b0;
        for (int i = 0; i < 15; i++) begin
            expect_val("t2_glitch3", 1'b0); cyc(1); check(cw);
        end
        cr = 1'b1; cyc(4); cr = 1'b0;
        expect_val("t2_pulse4", 1'b1); cyc(3); check(cw);
        expect_val("t2_pulse4_hold", 1'b1); cyc(15); check(cw);

        // Latched call held after departure until green.
        do_reset();
        cr = 1'b1; cyc(10); cr = 1'b0;
        expect_val("t3_latched", 1'b1); cyc(20); check(cw);
        expect_val("t3_hw_idle", 1'b0); check(hw);
        gc = 1'b1; cyc(1); gc = 1'b0;
        expect_val("t3_green_c1", 1'b1); check(cw);
        expect_val("t3_green_c2", 1'b0); cyc(1); check(cw);
        expect_val("t3_cleared", 1'b0); cyc(5); check(cw);

        // Green coincident with occ_rise: clear wins, output follows occ only.
        do_reset();
        hr = 1'b1; cyc(6);
        gh = 1'b1; cyc(1); gh = 1'b0;
        expect_val("t4_occ_on", 1'b1); check(hw);
        hr = 1'b0;
        expect_val("t4_occ_tail", 1'b1); cyc(6); check(hw);
        expect_val("t4_no_latch", 1'b0); cyc(1); check(hw);
        expect_val("t4_no_latch_hold", 1'b0); cyc(10); check(hw);

        // Prescaler instance: step rises within 53 cycles, 25-cycle pulse rejected.
        p_do_reset();
        p_hr = 1'b1;
        expect_val("t5_step_early", 1'b0); cyc(30); check(p_hw);
        expect_val("t5_step_rise", 1'b1); cyc(23); check(p_hw);
        p_hr = 1'b0;
        p_do_reset();
        p_hr = 1'b1; cyc(25); p_hr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expect_val("t5_pulse25", 1'b0); cyc(5); check(p_hw);
        end
        expect_val("t5_p_fault", 1'b0); check(p_fh);

        // Stuck loop: fault 60 ticks after occ rise, sticky after departure.
        do_reset();
        hr = 1'b1;
        expect_val("t6_hw_on", 1'b1); cyc(7); check(hw);
        expect_val("t6_fault_pre", 1'b0); cyc(57); check(fh);
        expect_val("t6_fault_set", FAULT_EN); cyc(6); check(fh);
        expect_val("t6_fc_indep", 1'b0); check(fc);
        hr = 1'b0;
        expect_val("t6_fault_sticky", FAULT_EN); cyc(20); check(fh);
        expect_val("t6_call_kept", 1'b1); check(hw);
        do_reset();
        #1;
        expect_val("t6_fault_rst", 1'b0); check(fh);
        expect_val("t6_hw_rst", 1'b0); check(hw);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_leftover: observed=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
